// File: rtl/johnson_arb_ctrl.sv
// ---------------------------------------------------------------------------
// johnson_arb_ctrl
//
// Two requesters share one 3-bit Johnson counter. A round-robin arbiter hands
// ownership to one requester at a time. The owner's direction and step count
// are latched at grant, and the counter then steps that many times. A
// one-cycle done pulse follows the last step, and ownership is then released.
//
// Optional feature (macro JOHNSON_ILLEGAL_RECOVER_EN):
//   defined   - the counter values 010 and 101 are not valid Johnson codes.
//               Either value is forced back to 000 on the next edge, in any
//               state, and err is high for that one cycle.
//   undefined - there is no detection logic, err is tied low, and illegal
//               values follow the normal shift rule.
//
// Ports:
//   clock            in   rising-edge clock
//   reset            in   asynchronous, active-low reset
//   req[1:0]         in   request level; bit i belongs to requester i
//   dir0, dir1       in   direction per requester (0 = up, 1 = down)
//   steps0, steps1   in   step count per requester, STEP_W bits
//   gnt[1:0]         out  one-hot grant; 00 while no requester owns the counter
//   busy             out  high in RUN and in DONE
//   done             out  one-cycle completion pulse
//   out[2:0]         out  shared Johnson counter value
//   err              out  illegal-code flag (only with the macro defined)
//   dbg_state[1:0]   out  FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
//
// Handshake: a requester holds its req bit high until it sees its gnt bit.
// req, dir and steps are sampled only on the edge that leaves IDLE. Changes
// to them after that edge are ignored until the block returns to IDLE.
// ---------------------------------------------------------------------------
module johnson_arb_ctrl #(
    parameter int STEP_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic              dir0,
    input  logic              dir1,
    input  logic [STEP_W-1:0] steps0,
    input  logic [STEP_W-1:0] steps1,
    output logic [1:0]        gnt,
    output logic              busy,
    output logic              done,
    output logic [2:0]        out,
    output logic              err,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        gnt_q,   gnt_d;
    logic [2:0]        out_q,   out_d;
    logic              dir_q,   dir_d;
    logic [STEP_W-1:0] rem_q,   rem_d;
    // ptr_q is the requester that wins when both are requesting.
    logic              ptr_q,   ptr_d;
    logic              pick;

    // One Johnson step. Up shifts left and inserts ~msb at the lsb. Down is
    // the exact reverse: it shifts right and inserts ~lsb at the msb.
    function automatic logic [2:0] johnson_step(input logic [2:0] v,
                                                input logic       down);
        if (down) return {~v[0], v[2:1]};
        else      return {v[1:0], ~v[2]};
    endfunction

    // Arbitration: a single requester always wins. When both request, the
    // pointer decides.
    always_comb begin
        pick = 1'b0;
        case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ptr_q;
            default: pick = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        out_d   = out_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;

        case (state_q)
            S_IDLE: begin
                gnt_d = 2'b00;
                if (req != 2'b00) begin
                    gnt_d = pick ? 2'b10 : 2'b01;
                    dir_d = pick ? dir1 : dir0;
                    rem_d = pick ? steps1 : steps0;
                    // A zero-step request completes with no counter motion.
                    if ((pick ? steps1 : steps0) == '0) state_d = S_DONE;
                    else                                state_d = S_RUN;
                end
            end
            S_RUN: begin
                out_d = johnson_step(out_q, dir_q);
                rem_d = rem_q - 1'b1;
                // rem_q cannot be 0 in RUN. The <= 1 test still ends the
                // operation if it ever were 0.
                if (rem_q <= STEP_W'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
                // Favour the requester that did not own the counter this time.
                ptr_d   = gnt_q[0];
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
            end
        endcase

`ifdef JOHNSON_ILLEGAL_RECOVER_EN
        // Recovery overrides any step that was pending this cycle.
        if (out_q == 3'b010 || out_q == 3'b101) out_d = 3'b000;
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            gnt_q   <= 2'b00;
            out_q   <= 3'b000;
            dir_q   <= 1'b0;
            rem_q   <= '0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            out_q   <= out_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef JOHNSON_ILLEGAL_RECOVER_EN
    logic err_q, err_d;

    always_comb begin
        err_d = (out_q == 3'b010) || (out_q == 3'b101);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign out       = out_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign done      = (state_q == S_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_johnson_arb_ctrl.sv
module tb_johnson_arb_ctrl;

  localparam int STEP_W = 4;

  logic              clock;
  logic              reset;
  logic [1:0]        req;
  logic              dir0;
  logic              dir1;
  logic [STEP_W-1:0] steps0;
  logic [STEP_W-1:0] steps1;
  logic [1:0]        gnt;
  logic              busy;
  logic              done;
  logic [2:0]        out;
  logic              err;
  logic [1:0]        dbg_state;

  int tests_run;
  int tests_failed;

  johnson_arb_ctrl #(.STEP_W(STEP_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .dir0      (dir0),
    .dir1      (dir1),
    .steps0    (steps0),
    .steps1    (steps1),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .out       (out),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Watchdog: the bench has to end on its own.
  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] e_gnt, input logic e_busy,
                           input logic e_done, input logic [2:0] e_out);
    check({tag, ".gnt"},  8'(gnt),  8'(e_gnt));
    check({tag, ".busy"}, 8'(busy), 8'(e_busy));
    check({tag, ".done"}, 8'(done), 8'(e_done));
    check({tag, ".out"},  8'(out),  8'(e_out));
    check({tag, ".err"},  8'(err),  8'(1'b0));
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [1:0] exp_g [4];
  logic [2:0] exp_o [4];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset  = 1'b0;
    req    = 2'b00;
    dir0   = 1'b0;
    dir1   = 1'b0;
    steps0 = '0;
    steps1 = '0;

    // Reset state.
    #3;
    check_all("reset", 2'b00, 1'b0, 1'b0, 3'b000);
    check("reset.state", 8'(dbg_state), 8'd0);
    #10 reset = 1'b1;
    tick();
    check_all("idle_after_reset", 2'b00, 1'b0, 1'b0, 3'b000);

    // Requester 0, up, 3 steps. Inputs change after grant and must be ignored.
    req = 2'b01; dir0 = 1'b0; steps0 = 4'd3;
    tick();
    check_all("r0_grant", 2'b01, 1'b1, 1'b0, 3'b000);
    req = 2'b00; dir0 = 1'b1; steps0 = 4'd7;
    tick(); check_all("r0_step1", 2'b01, 1'b1, 1'b0, 3'b001);
    tick(); check_all("r0_step2", 2'b01, 1'b1, 1'b0, 3'b011);
    tick(); check_all("r0_step3", 2'b01, 1'b1, 1'b1, 3'b111);
    tick(); check_all("r0_release", 2'b00, 1'b0, 1'b0, 3'b111);

    // Requester 1, up, 3 steps to wrap the counter back to 000.
    req = 2'b10; dir1 = 1'b0; steps1 = 4'd3;
    tick(); check_all("r1_grant", 2'b10, 1'b1, 1'b0, 3'b111);
    req = 2'b00;
    tick(); check_all("r1_up1", 2'b10, 1'b1, 1'b0, 3'b110);
    tick(); check_all("r1_up2", 2'b10, 1'b1, 1'b0, 3'b100);
    tick(); check_all("r1_up3", 2'b10, 1'b1, 1'b1, 3'b000);
    tick(); check_all("r1_up_release", 2'b00, 1'b0, 1'b0, 3'b000);

    // Requester 1, down, 2 steps from 000.
    req = 2'b10; dir1 = 1'b1; steps1 = 4'd2;
    tick(); check_all("r1_dn_grant", 2'b10, 1'b1, 1'b0, 3'b000);
    req = 2'b00;
    tick(); check_all("r1_dn1", 2'b10, 1'b1, 1'b0, 3'b100);
    tick(); check_all("r1_dn2", 2'b10, 1'b1, 1'b1, 3'b110);
    tick(); check_all("r1_dn_release", 2'b00, 1'b0, 1'b0, 3'b110);

    // Both requesting continuously with 1 step each: grants alternate, and the
    // pointer starts on requester 0 because requester 1 owned the counter last.
    exp_g[0] = 2'b01; exp_o[0] = 3'b100;
    exp_g[1] = 2'b10; exp_o[1] = 3'b000;
    exp_g[2] = 2'b01; exp_o[2] = 3'b001;
    exp_g[3] = 2'b10; exp_o[3] = 3'b011;
    req = 2'b11; dir0 = 1'b0; dir1 = 1'b0; steps0 = 4'd1; steps1 = 4'd1;
    for (int i = 0; i < 4; i++) begin
      tick(); check_all($sformatf("rr%0d_grant", i), exp_g[i], 1'b1, 1'b0,
                        (i == 0) ? 3'b110 : exp_o[i-1]);
      tick(); check_all($sformatf("rr%0d_done", i), exp_g[i], 1'b1, 1'b1, exp_o[i]);
      if (i == 3) req = 2'b00;
      tick(); check_all($sformatf("rr%0d_idle", i), 2'b00, 1'b0, 1'b0, exp_o[i]);
    end

    // Zero-step request goes straight to DONE, and the counter does not move.
    req = 2'b01; steps0 = 4'd0;
    tick(); check_all("zero_done", 2'b01, 1'b1, 1'b1, 3'b011);
    check("zero_state", 8'(dbg_state), 8'd2);
    req = 2'b00;
    tick(); check_all("zero_release", 2'b00, 1'b0, 1'b0, 3'b011);

    // Single requester held high is granted again after the idle cycle.
    req = 2'b01; steps0 = 4'd1; dir0 = 1'b1;
    tick(); check_all("solo_g1", 2'b01, 1'b1, 1'b0, 3'b011);
    tick(); check_all("solo_s1", 2'b01, 1'b1, 1'b1, 3'b001);
    tick(); check_all("solo_i1", 2'b00, 1'b0, 1'b0, 3'b001);
    tick(); check_all("solo_g2", 2'b01, 1'b1, 1'b0, 3'b001);
    req = 2'b00;
    tick(); check_all("solo_s2", 2'b01, 1'b1, 1'b1, 3'b000);
    tick(); check_all("solo_i2", 2'b00, 1'b0, 1'b0, 3'b000);

    // Reset during RUN with 2 steps remaining.
    req = 2'b01; dir0 = 1'b0; steps0 = 4'd4;
    tick(); check_all("rst_grant", 2'b01, 1'b1, 1'b0, 3'b000);
    req = 2'b00;
    tick(); check_all("rst_s1", 2'b01, 1'b1, 1'b0, 3'b001);
    tick(); check_all("rst_s2", 2'b01, 1'b1, 1'b0, 3'b011);
    #2 reset = 1'b0;
    #1 check_all("rst_async", 2'b00, 1'b0, 1'b0, 3'b000);
    tick(); check_all("rst_held", 2'b00, 1'b0, 1'b0, 3'b000);
    #3 reset = 1'b1;
    tick(); check_all("rst_released", 2'b00, 1'b0, 1'b0, 3'b000);

    // After reset the pointer favours requester 0 again.
    req = 2'b11; steps0 = 4'd1; steps1 = 4'd1; dir1 = 1'b1;
    tick(); check_all("post_rst_grant", 2'b01, 1'b1, 1'b0, 3'b000);
    req = 2'b00;
    tick(); check_all("post_rst_step", 2'b01, 1'b1, 1'b1, 3'b001);
    tick(); check_all("post_rst_idle", 2'b00, 1'b0, 1'b0, 3'b001);

`ifdef JOHNSON_ILLEGAL_RECOVER_EN
    // Illegal code 101 recovers to 000 on the next edge, with a one-cycle err.
    force dut.out_q = 3'b101;
    #1 release dut.out_q;
    tick();
    check("illegal_out", 8'(out), 8'd0);
    check("illegal_err", 8'(err), 8'd1);
    tick();
    check("illegal_err_clear", 8'(err), 8'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
